// File: rtl/shift_arbiter_seq.sv
// Two-requester round-robin front end sharing one iterative shift engine.
// One bit position is shifted per clock; completion is a one-cycle done pulse tagged with the requester ID.
module shift_arbiter_seq #(
  parameter int WIDTH = 16,
  parameter int SHW   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [1:0]       op0,
  input  logic [WIDTH-1:0] a0,
  input  logic [SHW-1:0]   shamt0,
  input  logic             req1,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a1,
  input  logic [SHW-1:0]   shamt1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] result
);

  localparam logic [1:0]     OP_SLL  = 2'b00;
  localparam logic [1:0]     OP_SRL  = 2'b01;
  localparam logic [1:0]     OP_SRA  = 2'b10;
  localparam logic [1:0]     OP_ROL  = 2'b11;
  localparam logic [SHW-1:0] CNT_ONE = SHW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [1:0]       op_q, op_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             done_id_q, done_id_d;
  logic             done_q, done_d;
  logic             pick0_s, pick1_s;

  // Single-bit step of the shared engine
  function automatic logic [WIDTH-1:0] shift_one(input logic [WIDTH-1:0] d, input logic [1:0] op);
    logic [WIDTH-1:0] r;
    case (op)
      OP_SLL:  r = {d[WIDTH-2:0], 1'b0};
      OP_SRL:  r = {1'b0, d[WIDTH-1:1]};
      OP_SRA:  r = {d[WIDTH-1], d[WIDTH-1:1]};
      OP_ROL:  r = {d[WIDTH-2:0], d[WIDTH-1]};
      default: r = d;
    endcase
    return r;
  endfunction

  // Round-robin pick; last_q high means requester 1 was granted last
  always_comb begin
    pick0_s = 1'b0;
    pick1_s = 1'b0;
    if (req0 && req1) begin
      pick0_s = last_q;
      pick1_s = ~last_q;
    end else begin
      pick0_s = req0;
      pick1_s = req1;
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (pick0_s || pick1_s) begin
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output decode; grants exist only while idle
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    busy = 1'b1;
    case (state_q)
      ST_IDLE: begin
        gnt0 = pick0_s;
        gnt1 = pick1_s;
        busy = 1'b0;
      end
      ST_SHIFT: busy = 1'b1;
      ST_DONE:  busy = 1'b1;
      default:  busy = 1'b1;
    endcase
  end

  // Datapath next values: capture on accept, step while counting, publish on entry to DONE
  always_comb begin
    data_d    = data_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    id_d      = id_q;
    last_d    = last_q;
    result_d  = result_q;
    done_id_d = done_id_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick0_s) begin
          data_d = a0;
          op_d   = op0;
          cnt_d  = shamt0;
          id_d   = 1'b0;
          last_d = 1'b0;
        end else if (pick1_s) begin
          data_d = a1;
          op_d   = op1;
          cnt_d  = shamt1;
          id_d   = 1'b1;
          last_d = 1'b1;
        end else begin
          data_d = data_q;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == '0) begin
          result_d  = data_q;
          done_id_d = id_q;
          done_d    = 1'b1;
        end else begin
          data_d = shift_one(data_q, op_q);
          cnt_d  = cnt_q - CNT_ONE;
        end
      end
      ST_DONE: done_d = 1'b0;
      default: done_d = 1'b0;
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_q    <= '0;
      op_q      <= 2'b00;
      cnt_q     <= '0;
      id_q      <= 1'b0;
      last_q    <= 1'b1;
      result_q  <= '0;
      done_id_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      data_q    <= data_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      id_q      <= id_d;
      last_q    <= last_d;
      result_q  <= result_d;
      done_id_q <= done_id_d;
      done_q    <= done_d;
    end
  end

  assign done    = done_q;
  assign done_id = done_id_q;
  assign result  = result_q;

endmodule

// File: tb/tb_shift_arbiter_seq.sv
// Scoreboard bench for shift_arbiter_seq: expectations are queued at accept and matched on done.
module tb_shift_arbiter_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [1:0]  op0, op1;
  logic [15:0] a0, a1;
  logic [3:0]  shamt0, shamt1;
  logic        gnt0, gnt1, busy, done, done_id;
  logic [15:0] result;

  shift_arbiter_seq #(.WIDTH(16), .SHW(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .op0(op0), .a0(a0), .shamt0(shamt0),
    .req1(req1), .op1(op1), .a1(a1), .shamt1(shamt1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done),
    .done_id(done_id), .result(result)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        id;
    logic [15:0] res;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   rst_pulsed = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Monitor: protocol invariants every cycle, scoreboard match on done
  exp_t        mon_e;
  logic [15:0] prev_result;
  logic        prev_done;
  initial begin
    prev_result = 16'h0000;
    prev_done   = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      check("gnt_exclusive", 32'(gnt0 & gnt1), 32'd0);
      check("gnt_while_busy", 32'((gnt0 | gnt1) & busy), 32'd0);
      if (prev_done) check("busy_after_done", 32'(busy), 32'd0);
      if (done) begin
        if (sb.size() == 0) begin
          check("done_unexpected", 32'd1, 32'd0);
        end else begin
          mon_e = sb.pop_front();
          check("result", 32'(result), 32'(mon_e.res));
          check("done_id", 32'(done_id), 32'(mon_e.id));
          check("done_cycle", 32'(cyc), 32'(mon_e.cyc));
        end
      end else if (!rst_pulsed) begin
        check("result_hold", 32'(result), 32'(prev_result));
      end
      prev_result = result;
      prev_done   = done;
      rst_pulsed  = 1'b0;
    end
  end

  task automatic do_req(input bit id, input logic [1:0] op, input logic [15:0] a,
                        input logic [3:0] sh, input logic [15:0] exp_res,
                        output int acc, output int waited);
    bit   got;
    exp_t e;
    @(negedge clk);
    if (id == 1'b0) begin
      req0 = 1'b1; op0 = op; a0 = a; shamt0 = sh;
    end else begin
      req1 = 1'b1; op1 = op; a1 = a; shamt1 = sh;
    end
    got = 1'b0; waited = 0; acc = -1;
    while (!got && waited < 300) begin
      #1;
      if ((id == 1'b0 && gnt0) || (id == 1'b1 && gnt1)) got = 1'b1;
      else begin
        @(negedge clk);
        waited++;
      end
    end
    if (!got) begin
      check("gnt_timeout", 32'd0, 32'd1);
      if (id == 1'b0) req0 = 1'b0; else req1 = 1'b0;
      return;
    end
    acc   = cyc;
    e.id  = id;
    e.res = exp_res;
    e.cyc = cyc + int'(sh) + 2;
    sb.push_back(e);
    grant_log.push_back(int'(id));
    @(posedge clk);
    #1;
    // scramble operands after the accept edge; the op in flight must not notice
    if (id == 1'b0) begin
      req0 = 1'b0; op0 = ~op0; a0 = ~a0; shamt0 = ~shamt0;
    end else begin
      req1 = 1'b0; op1 = ~op1; a1 = ~a1; shamt1 = ~shamt1;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  task automatic pulse_rst(input string tag);
    @(posedge clk);
    #2;
    rst = 1'b1;
    rst_pulsed = 1'b1;
    #1;
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
    check({tag, "_done_id"}, 32'(done_id), 32'd0);
    sb.delete();
    #1;
    rst = 1'b0;
  endtask

  int acc, w, acc0, acc1, w0, w1, ta, tw, tb_acc, tb_w;

  initial begin
    rst = 1'b1;
    req0 = 1'b0; op0 = 2'b00; a0 = 16'h0000; shamt0 = 4'd0;
    req1 = 1'b0; op1 = 2'b00; a1 = 16'h0000; shamt1 = 4'd0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_done_id", 32'(done_id), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_gnt0_idle", 32'(gnt0), 32'd0);
    req1 = 1'b1;
    #1;
    check("rst_gnt1_follows_req", 32'(gnt1), 32'd1);
    req1 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // SLL basic
    do_req(1'b0, 2'b00, 16'h0005, 4'd4, 16'h0050, acc, w);
    check("t1_gnt_same_cycle", 32'(w), 32'd0);
    wait_drain();

    // pass-through then SLL by 2
    do_req(1'b1, 2'b11, 16'hABCD, 4'd0, 16'hABCD, acc, w);
    do_req(1'b1, 2'b00, 16'h0005, 4'd2, 16'h0014, acc, w);
    wait_drain();

    // op coverage at the maximum shift amount
    do_req(1'b0, 2'b10, 16'h8000, 4'd15, 16'hFFFF, acc, w);
    do_req(1'b1, 2'b01, 16'h8000, 4'd15, 16'h0001, acc, w);
    do_req(1'b0, 2'b11, 16'h8001, 4'd1,  16'h0003, acc, w);
    do_req(1'b1, 2'b00, 16'hFFFF, 4'd15, 16'h8000, acc, w);
    wait_drain();

    // busy stall: requester 1 arrives while requester 0 is shifting
    fork
      begin
        do_req(1'b0, 2'b01, 16'hF000, 4'd3, 16'h1E00, acc0, w0);
      end
      begin
        repeat (2) @(negedge clk);
        do_req(1'b1, 2'b10, 16'h8F00, 4'd4, 16'hF8F0, acc1, w1);
      end
    join
    check("t6_stall_accept", 32'(acc1), 32'(acc0 + 6));
    wait_drain();

    // reset mid-operation
    do_req(1'b0, 2'b00, 16'h0001, 4'd10, 16'h0400, acc, w);
    check("t5_result_nonzero", 32'(result != 16'h0000), 32'd1);
    repeat (5) @(posedge clk);
    pulse_rst("t5_rst");
    repeat (20) @(negedge clk);
    check("t5_idle_after_rst", 32'(busy), 32'd0);
    do_req(1'b0, 2'b01, 16'h00F0, 4'd4, 16'h000F, acc, w);
    wait_drain();

    // arbitration from reset: pointer must be back at 1 so requester 0 wins the tie
    pulse_rst("t4_rst");
    grant_log.delete();
    fork
      begin
        do_req(1'b0, 2'b00, 16'h0003, 4'd1, 16'h0006, ta, tw);
        do_req(1'b0, 2'b01, 16'h0080, 4'd7, 16'h0001, ta, tw);
      end
      begin
        do_req(1'b1, 2'b11, 16'h8000, 4'd2, 16'h0002, tb_acc, tb_w);
      end
    join
    wait_drain();
    check("t4_grant_count", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check("t4_grant_0", 32'(grant_log[0]), 32'd0);
      check("t4_grant_1", 32'(grant_log[1]), 32'd1);
      check("t4_grant_2", 32'(grant_log[2]), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
